// File: rtl/uart_proto_pkg.sv
// Peer link protocol constants shared by the uart rx decoder and tx side.
// Byte codes, heartbeat timing and decoder state/kind types.
package uart_proto_pkg;

  localparam logic [7:0] MSG_LOST  = 8'h4C;
  localparam logic [7:0] MSG_READY = 8'h52;

  localparam int unsigned HEARTBEAT_CYCLES   = 65_000_000;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 100_000_000;
  localparam int unsigned CNT_W_DEF          = 27;

  typedef enum logic {
    S_IDLE,
    S_DECODE
  } dec_state_e;

  typedef enum logic [1:0] {
    K_LOST,
    K_READY,
    K_BAD
  } msg_kind_e;

  function automatic msg_kind_e classify(input logic [7:0] b);
    msg_kind_e k;
    case (b)
      MSG_LOST:  k = K_LOST;
      MSG_READY: k = K_READY;
      default:   k = K_BAD;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/link_watchdog.sv
// Peer heartbeat watchdog: alive rises on kick, drops after
// TIMEOUT_CYCLES cycles without another kick.
module link_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
  parameter int unsigned CNT_W          = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic kick,
  output logic alive
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // kick on the expiry cycle wins over the timeout
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= '0;
      alive <= 1'b0;
    end else if (kick) begin
      cnt   <= '0;
      alive <= 1'b1;
    end else if (alive) begin
      if (cnt == LAST) begin
        cnt   <= '0;
        alive <= 1'b0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_msg_decoder.sv
// Pops peer bytes from the uart rx FIFO and turns them into event
// pulses, sticky game-over status, a bad-byte count and link liveness.
module uart_msg_decoder
  import uart_proto_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  input  logic       clr_status,
  output logic       rd_uart,
  output logic       peer_lost,
  output logic       peer_ready,
  output logic       peer_game_over,
  output logic       peer_alive,
  output logic [7:0] last_byte,
  output logic [7:0] bad_cnt
);

  dec_state_e state;
  dec_state_e state_nx;
  msg_kind_e  kind;

  logic [7:0] byte_q;
  logic       pop;
  logic       is_lost;
  logic       is_ready;
  logic       is_bad;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (pop) state_nx = S_DECODE;
      S_DECODE: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    pop      = 1'b0;
    is_lost  = 1'b0;
    is_ready = 1'b0;
    is_bad   = 1'b0;
    kind     = classify(byte_q);
    unique case (state)
      S_IDLE: pop = en && !rx_empty;
      S_DECODE: begin
        unique case (1'b1)
          kind == K_LOST:  is_lost  = 1'b1;
          kind == K_READY: is_ready = 1'b1;
          default:         is_bad   = 1'b1;
        endcase
      end
      default: pop = 1'b0;
    endcase
  end

  // rd_uart rises together with the capture; the FIFO pops one
  // cycle later, while the head byte is already held in byte_q
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_uart        <= 1'b0;
      peer_lost      <= 1'b0;
      peer_ready     <= 1'b0;
      peer_game_over <= 1'b0;
      byte_q         <= 8'h00;
      last_byte      <= 8'h00;
      bad_cnt        <= 8'h00;
    end else begin
      rd_uart    <= pop;
      peer_lost  <= is_lost;
      peer_ready <= is_ready;
      if (pop) begin
        byte_q    <= r_data;
        last_byte <= r_data;
      end
      if (is_lost)
        peer_game_over <= 1'b1;
      else if (is_ready || clr_status)
        peer_game_over <= 1'b0;
      if (clr_status)
        bad_cnt <= 8'h00;
      else if (is_bad && bad_cnt != 8'hFF)
        bad_cnt <= bad_cnt + 8'd1;
    end
  end

  link_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_wdog (
    .clk  (clk),
    .rst  (rst),
    .kick (is_ready),
    .alive(peer_alive)
  );

endmodule

// File: tb/tb_uart_msg_decoder.sv
// Bench for uart_msg_decoder: FIFO model, table vectors, corner
// sequences and random traffic against a reference model.
module tb_uart_msg_decoder;

  localparam int T = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       rx_empty = 1'b1;
  logic       clr_status = 1'b0;
  logic [7:0] r_data = 8'h00;
  logic       rd_uart;
  logic       peer_lost;
  logic       peer_ready;
  logic       peer_game_over;
  logic       peer_alive;
  logic [7:0] last_byte;
  logic [7:0] bad_cnt;

  always #5 clk = ~clk;

  uart_msg_decoder #(
    .TIMEOUT_CYCLES(T),
    .CNT_W         (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .rx_empty      (rx_empty),
    .r_data        (r_data),
    .clr_status    (clr_status),
    .rd_uart       (rd_uart),
    .peer_lost     (peer_lost),
    .peer_ready    (peer_ready),
    .peer_game_over(peer_game_over),
    .peer_alive    (peer_alive),
    .last_byte     (last_byte),
    .bad_cnt       (bad_cnt)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [7:0] fifo[$];

  // reference model: expected visible outputs for the current cycle
  bit         m_rd, m_lost, m_ready, m_go;
  logic [7:0] m_byte, m_last;
  int         m_bad;
  bit         m_rvalid;
  int         m_lastr;

  typedef struct {
    logic [7:0] b;
    bit         lost;
    bit         ready;
    int         inc;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int exp_alive();
    return (m_rvalid && (cyc - m_lastr) < T) ? 1 : 0;
  endfunction

  task automatic drive_fifo();
    rx_empty = (fifo.size() == 0);
    r_data   = rx_empty ? 8'h00 : fifo[0];
  endtask

  task automatic step();
    bit         popped;
    bit         dec;
    bit         nrd;
    bit         got_r;
    logic [7:0] db;
    drive_fifo();
    popped = rd_uart;
    check("pop_on_empty", int'(popped && fifo.size() == 0), 0);
    got_r = 1'b0;
    if (!rst) begin
      m_rd = 0; m_lost = 0; m_ready = 0; m_go = 0;
      m_last = 8'h00; m_bad = 0; m_rvalid = 0;
    end else begin
      dec = m_rd;
      db  = m_byte;
      nrd = !m_rd && en && !rx_empty;
      if (nrd) begin
        m_byte = r_data;
        m_last = r_data;
      end
      m_rd    = nrd;
      m_lost  = dec && db == 8'h4C;
      m_ready = dec && db == 8'h52;
      if (m_lost) m_go = 1;
      else if (m_ready || clr_status) m_go = 0;
      if (clr_status) m_bad = 0;
      else if (dec && !m_lost && !m_ready && m_bad < 255) m_bad++;
      got_r = m_ready;
    end
    @(posedge clk);
    cyc++;
    if (got_r) begin
      m_rvalid = 1;
      m_lastr  = cyc;
    end
    #1;
    if (popped && fifo.size() > 0) void'(fifo.pop_front());
    drive_fifo();
    check("rd_uart", int'(rd_uart), int'(m_rd));
    check("peer_lost", int'(peer_lost), int'(m_lost));
    check("peer_ready", int'(peer_ready), int'(m_ready));
    check("game_over", int'(peer_game_over), int'(m_go));
    check("peer_alive", int'(peer_alive), exp_alive());
    check("last_byte", int'(last_byte), int'(m_last));
    check("bad_cnt", int'(bad_cnt), m_bad);
  endtask

  initial begin
    int base, hi, p, mn;
    vecs[0] = '{8'h4C, 1, 0, 0};
    vecs[1] = '{8'h52, 0, 1, 0};
    vecs[2] = '{8'h41, 0, 0, 1};
    vecs[3] = '{8'h00, 0, 0, 1};
    vecs[4] = '{8'hFF, 0, 0, 1};
    vecs[5] = '{8'h4D, 0, 0, 1};
    vecs[6] = '{8'h51, 0, 0, 1};
    vecs[7] = '{8'h6C, 0, 0, 1};
    vecs[8] = '{8'h72, 0, 0, 1};
    m_rd = 0; m_lost = 0; m_ready = 0; m_go = 0;
    m_byte = 0; m_last = 0; m_bad = 0; m_rvalid = 0; m_lastr = 0;

    // reset holds everything even with a byte waiting
    rst = 0; en = 1;
    fifo.push_back(8'h4C);
    step(); step();
    check("t1_rd", int'(rd_uart), 0);
    check("t1_lost", int'(peer_lost), 0);
    check("t1_alive", int'(peer_alive), 0);
    check("t1_last", int'(last_byte), 0);
    fifo.delete();
    rst = 1;
    step();

    // single 'R'
    fifo.push_back(8'h52);
    step();
    check("t2_rd", int'(rd_uart), 1);
    step();
    check("t2_ready", int'(peer_ready), 1);
    check("t2_alive", int'(peer_alive), 1);
    check("t2_last", int'(last_byte), 8'h52);

    // back-to-back L, R, A
    clr_status = 1; step(); clr_status = 0;
    fifo.push_back(8'h4C); fifo.push_back(8'h52); fifo.push_back(8'h41);
    for (int k = 1; k <= 6; k++) begin
      step();
      check("t3_rd_pattern", int'(rd_uart), k % 2);
      if (k == 2) check("t3_go_set", int'(peer_game_over), 1);
      if (k == 4) check("t3_go_clr", int'(peer_game_over), 0);
      if (k == 6) check("t3_bad", int'(bad_cnt), 1);
    end

    // table of byte classifications
    foreach (vecs[i]) begin
      base = m_bad;
      fifo.push_back(vecs[i].b);
      step(); step();
      check("vec_lost", int'(peer_lost), int'(vecs[i].lost));
      check("vec_ready", int'(peer_ready), int'(vecs[i].ready));
      check("vec_bad", int'(bad_cnt), base + vecs[i].inc);
      check("vec_last", int'(last_byte), int'(vecs[i].b));
    end

    // timeout length after a single 'R'
    fifo.push_back(8'h52);
    step(); step();
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (!peer_alive) break;
      hi++;
      step();
    end
    check("t4_alive_len", hi, T);

    // 'R' decoded on the expiry cycle keeps the link alive
    fifo.push_back(8'h52);
    step(); step();
    p = cyc;
    mn = int'(peer_alive);
    for (int i = 0; i < 18; i++) begin
      step();
      if (!peer_alive) mn = 0;
    end
    fifo.push_back(8'h52);
    step();
    if (!peer_alive) mn = 0;
    step();
    if (!peer_alive) mn = 0;
    check("t4_second_r_cycle", cyc - p, T);
    check("t4_second_r", int'(peer_ready), 1);
    for (int i = 0; i < 5; i++) begin
      step();
      if (!peer_alive) mn = 0;
    end
    check("t4_alive_cont", mn, 1);

    // saturation and clear
    for (int i = 0; i < 300; i++) fifo.push_back(8'hFF);
    for (int i = 0; i < 605; i++) step();
    check("t5_sat", int'(bad_cnt), 8'hFF);
    clr_status = 1; step(); clr_status = 0;
    check("t5_clr", int'(bad_cnt), 0);

    // clr with 'L' decode: 'L' wins on game_over, count cleared
    fifo.push_back(8'h41);
    step(); step();
    fifo.push_back(8'h4C);
    step();
    clr_status = 1; step(); clr_status = 0;
    check("t5_clr_l_go", int'(peer_game_over), 1);
    check("t5_clr_l_bad", int'(bad_cnt), 0);

    // clr with bad decode ends at 0
    fifo.push_back(8'h41);
    step(); step();
    fifo.push_back(8'h41);
    step();
    clr_status = 1; step(); clr_status = 0;
    check("t5_clr_bad", int'(bad_cnt), 0);

    // en gating and reset during decode
    en = 0;
    fifo.push_back(8'h4C);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_no_rd", int'(rd_uart), 0);
    end
    en = 1;
    step();
    check("t6_rd", int'(rd_uart), 1);
    rst = 0;
    step();
    check("t6_rst_lost", int'(peer_lost), 0);
    rst = 1;
    step();
    check("t6_after_lost", int'(peer_lost), 0);

    // en falling during decode still completes it
    fifo.push_back(8'h4C);
    step();
    en = 0;
    step();
    check("t6_en_fall", int'(peer_lost), 1);
    en = 1;

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      rst        = ($urandom_range(0, 199) != 0);
      en         = ($urandom_range(0, 9) != 0);
      clr_status = ($urandom_range(0, 29) == 0);
      if (fifo.size() < 4 && $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0:       fifo.push_back(8'h4C);
          1:       fifo.push_back(8'h52);
          2:       fifo.push_back(8'($urandom_range(0, 255)));
          default: fifo.push_back(8'h52);
        endcase
      end
      step();
    end
    rst = 1; en = 1; clr_status = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
